gray12_ptr_rx: RTL



---
 rtl/gray12_pkg.sv | 112 +++++++++++
 rtl/gray_sync.sv | 38 +++
 rtl/gray12_ptr_rx.sv | 101 ++++++++++
 3 files changed

// File: rtl/gray12_pkg.sv
// ============================================================================
//  Module      : gray12_pkg
//  Description : Shared definitions for the 12-state Gray pointer: code table,
//                mod-12 arithmetic and Gray/index conversion helpers.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package gray12_pkg;

    localparam int unsigned N_IDX   = 12;
    localparam logic [3:0]  IDX_MAX = 4'd11;

    localparam logic [3:0] GRAY_0  = 4'b0000;
    localparam logic [3:0] GRAY_1  = 4'b0001;
    localparam logic [3:0] GRAY_2  = 4'b0011;
    localparam logic [3:0] GRAY_3  = 4'b0010;
    localparam logic [3:0] GRAY_4  = 4'b0110;
    localparam logic [3:0] GRAY_5  = 4'b0111;
    localparam logic [3:0] GRAY_6  = 4'b0101;
    localparam logic [3:0] GRAY_7  = 4'b0100;
    localparam logic [3:0] GRAY_8  = 4'b1100;
    localparam logic [3:0] GRAY_9  = 4'b1101;
    localparam logic [3:0] GRAY_10 = 4'b1001;
    localparam logic [3:0] GRAY_11 = 4'b1000;

    typedef struct packed {
        logic       illegal;
        logic [3:0] idx;
    } gray_dec_t;

    // Wraps 11 -> 0; out-of-range inputs also fold back to 0.
    function automatic logic [3:0] mod12_inc(input logic [3:0] a);
        logic [3:0] r;
        if (a >= IDX_MAX) begin
            r = 4'd0;
        end else begin
            r = a + 4'd1;
        end
        return r;
    endfunction

    // True modulo-12 difference a - b for a, b in 0..11.
    function automatic logic [3:0] mod12_sub(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] wide;
        if (a >= b) begin
            wide = {1'b0, a} - {1'b0, b};
        end else begin
            wide = {1'b0, a} + 5'd12 - {1'b0, b};
        end
        return wide[3:0];
    endfunction

    function automatic logic [3:0] idx_to_gray(input logic [3:0] idx);
        logic [3:0] g;
        case (idx)
            4'd0:    g = GRAY_0;
            4'd1:    g = GRAY_1;
            4'd2:    g = GRAY_2;
            4'd3:    g = GRAY_3;
            4'd4:    g = GRAY_4;
            4'd5:    g = GRAY_5;
            4'd6:    g = GRAY_6;
            4'd7:    g = GRAY_7;
            4'd8:    g = GRAY_8;
            4'd9:    g = GRAY_9;
            4'd10:   g = GRAY_10;
            4'd11:   g = GRAY_11;
            default: g = GRAY_0;
        endcase
        return g;
    endfunction

    function automatic gray_dec_t gray_decode(input logic [3:0] g);
        gray_dec_t d;
        d.illegal = 1'b0;
        case (g)
            GRAY_0:  d.idx = 4'd0;
            GRAY_1:  d.idx = 4'd1;
            GRAY_2:  d.idx = 4'd2;
            GRAY_3:  d.idx = 4'd3;
            GRAY_4:  d.idx = 4'd4;
            GRAY_5:  d.idx = 4'd5;
            GRAY_6:  d.idx = 4'd6;
            GRAY_7:  d.idx = 4'd7;
            GRAY_8:  d.idx = 4'd8;
            GRAY_9:  d.idx = 4'd9;
            GRAY_10: d.idx = 4'd10;
            GRAY_11: d.idx = 4'd11;
            default: begin
                d.idx     = 4'd0;
                d.illegal = 1'b1;
            end
        endcase
        return d;
    endfunction

    function automatic logic [3:0] gray_to_idx(input logic [3:0] g);
        gray_dec_t d;
        d = gray_decode(g);
        return d.idx;
    endfunction

    function automatic logic gray_is_illegal(input logic [3:0] g);
        gray_dec_t d;
        d = gray_decode(g);
        return d.illegal;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gray_sync.sv
// ============================================================================
//  Module      : gray_sync
//  Description : SYNC_STAGES-deep 4-bit synchronizer chain, kept separate so
//                CDC constraints can target it by hierarchy.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module gray_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] stage_q [SYNC_STAGES];

    // Pure flop chain: any logic between stages would defeat the synchronizer.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= 4'b0000;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/gray12_ptr_rx.sv
// ============================================================================
//  Module      : gray12_ptr_rx
//  Description : Read side of the mod-12 Gray elastic-buffer pointer: syncs and
//                checks the remote write pointer, keeps the local read pointer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module gray12_ptr_rx
    import gray12_pkg::*;
#(
    parameter int SYNC_STAGES = 2   // legal range 2..4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] gray_in,
    input  logic       rd_en,
    input  logic       clr_err,
    output logic [3:0] wr_bin,
    output logic [3:0] rd_bin,
    output logic [3:0] rd_gray,
    output logic [3:0] count,
    output logic       empty,
    output logic       full,
    output logic [1:0] err
);

    logic [3:0] sync_gray;
    gray_dec_t  sync_dec;

    logic [3:0] wr_bin_q,  wr_bin_d;
    logic [3:0] rd_bin_q,  rd_bin_d;
    logic [3:0] rd_gray_q, rd_gray_d;
    logic [1:0] err_q,     err_d;
    logic [3:0] count_w;
    logic       empty_w;

    gray_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_gray_sync (
        .clk   (clk),
        .reset (reset),
        .d     (gray_in),
        .q     (sync_gray)
    );

    assign sync_dec = gray_decode(sync_gray);
    assign count_w  = mod12_sub(wr_bin_q, rd_bin_q);
    assign empty_w  = (count_w == 4'd0);

    always_comb begin
        wr_bin_d  = wr_bin_q;
        rd_bin_d  = rd_bin_q;
        rd_gray_d = rd_gray_q;
        err_d     = clr_err ? 2'b00 : err_q;

        // An illegal code leaves wr_bin alone; a legal jump resyncs but flags.
        if (sync_dec.illegal) begin
            err_d[0] = 1'b1;
        end else if (sync_dec.idx != wr_bin_q) begin
            wr_bin_d = sync_dec.idx;
            if (sync_dec.idx != mod12_inc(wr_bin_q)) begin
                err_d[0] = 1'b1;
            end
        end

        if (rd_en) begin
            if (empty_w) begin
                err_d[1] = 1'b1;
            end else begin
                rd_bin_d  = mod12_inc(rd_bin_q);
                rd_gray_d = idx_to_gray(rd_bin_d);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bin_q  <= 4'd0;
            rd_bin_q  <= 4'd0;
            rd_gray_q <= GRAY_0;
            err_q     <= 2'b00;
        end else begin
            wr_bin_q  <= wr_bin_d;
            rd_bin_q  <= rd_bin_d;
            rd_gray_q <= rd_gray_d;
            err_q     <= err_d;
        end
    end

    assign wr_bin  = wr_bin_q;
    assign rd_bin  = rd_bin_q;
    assign rd_gray = rd_gray_q;
    assign count   = count_w;
    assign empty   = empty_w;
    assign full    = (count_w == IDX_MAX);
    assign err     = err_q;

endmodule

`default_nettype wire
